// File: rtl/cdc_top_if.sv
// USB receive byte stream between the byte source and the command dispatcher.
//   usb_data_in        received byte
//   usb_data_valid_in  one-clk strobe qualifying usb_data_in
// master drives the stream, slave (cdc_top) consumes it.
interface cdc_top_if;
  logic [7:0] usb_data_in;
  logic       usb_data_valid_in;

  modport master (output usb_data_in, output usb_data_valid_in);
  modport slave  (input  usb_data_in, input  usb_data_valid_in);
endinterface

// File: rtl/cdc_top.sv
// Command dispatcher for the USB byte stream.
// Parses frames  AA 55 cmd lenH lenL payload[len] chk  (chk = sum of cmd..payload mod 256).
//   CMD_CUSTOM : uploads a 14-bit offset-binary waveform into sample RAM and
//                optionally plays it back on dac_data at a fractional rate.
//   CMD_DAC    : latches DDS parameters for the downstream DAC handler and
//                releases the DAC bus from custom playback.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   usb                 byte stream (cdc_top_if.slave)
//   dac_data            signed sample (0 when custom_wave_active=0)
//   custom_wave_active  custom waveform owns the DAC bus
//   playback_active     playback accumulator running
//   ram_rd_addr         current playback read address
//   dds_wave_type/freq_word/phase_word  latched DDS fields
//   dds_update          1-clk pulse on DDS field update
//   frame_error         1-clk pulse on rejected frame
module cdc_top #(
  parameter int          MAX_SAMPLES = 4096,
  parameter logic [7:0]  CMD_CUSTOM  = 8'hFC,
  parameter logic [7:0]  CMD_DAC     = 8'hFD,
  localparam int         AW          = $clog2(MAX_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cdc_top_if.slave             usb,
  output logic signed [13:0]   dac_data,
  output logic                 custom_wave_active,
  output logic                 playback_active,
  output logic [AW-1:0]        ram_rd_addr,
  output logic [1:0]           dds_wave_type,
  output logic [31:0]          dds_freq_word,
  output logic [31:0]          dds_phase_word,
  output logic                 dds_update,
  output logic                 frame_error
);

  localparam logic [AW:0] DEPTH = (AW+1)'(MAX_SAMPLES);

  typedef enum logic [2:0] {IDLE, SYNC, CMD, LEN_H, LEN_L, PAYLOAD, CHK} state_t;

  typedef struct packed {
    logic [1:0]  wave;
    logic [31:0] freq;
    logic [31:0] phase;
  } dds_t;

  state_t      state;
  logic [7:0]  din;
  logic        din_vld;
  logic [7:0]  cmd;
  logic [15:0] len;
  logic [15:0] idx;        // payload byte index
  logic [7:0]  sum;        // running checksum

  // upload staging, committed only when the frame checks out
  logic        play_req;
  logic [15:0] cnt_new;
  logic [31:0] rate_new;
  logic [7:0]  lo_byte;
  logic [AW:0] wr_cnt;     // samples written so far, saturates at DEPTH
  dds_t        dds_new;

  // committed playback configuration
  logic [AW:0] cnt_r;
  logic [31:0] rate_r;
  logic        ram_valid;
  logic [19:0] frac;

  // sample RAM and read pipeline
  logic [13:0] ram [MAX_SAMPLES];
  logic [13:0] ram_q;
  logic signed [13:0] dac_q;
  logic        ram_we;
  logic        wr_ok;

  logic [20:0] step;
  logic [20:0] acc_sum;
  logic        addr_last;
  logic        len_ok;
  logic        up_ok;

  assign din     = usb.usb_data_in;
  assign din_vld = usb.usb_data_valid_in;

  // Rates at or above 2^20 saturate to one advance per clock.
  assign step      = (|rate_r[31:20]) ? 21'h10_0000 : {1'b0, rate_r[19:0]};
  assign acc_sum   = {1'b0, frac} + step;
  assign addr_last = ({1'b0, ram_rd_addr} == cnt_r - 1'b1);

  // 18 bits so 7 + 2*cnt cannot wrap for any 16-bit cnt.
  assign len_ok = ({2'b00, len} == ({1'b0, cnt_new, 1'b0} + 18'd7));
  assign up_ok  = (din == sum) && (cnt_new != 16'd0) &&
                  (cnt_new <= 16'(MAX_SAMPLES)) && len_ok;

  // Sample k sits at payload bytes 7+2k (low) and 8+2k (high); write on the high byte.
  assign wr_ok  = (wr_cnt < DEPTH);
  assign ram_we = din_vld && (state == PAYLOAD) && (cmd == CMD_CUSTOM) &&
                  (idx >= 16'd8) && !idx[0] && wr_ok;

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_cnt[AW-1:0]] <= {din[5:0], lo_byte};
    ram_q <= ram[ram_rd_addr];
  end

  // Second pipeline stage: offset binary -> two's complement by MSB flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dac_q <= '0;
    else        dac_q <= {~ram_q[13], ram_q[12:0]};
  end

  assign dac_data = custom_wave_active ? dac_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cmd                <= '0;
      len                <= '0;
      idx                <= '0;
      sum                <= '0;
      play_req           <= 1'b0;
      cnt_new            <= '0;
      rate_new           <= '0;
      lo_byte            <= '0;
      wr_cnt             <= '0;
      dds_new            <= '0;
      cnt_r              <= '0;
      rate_r             <= '0;
      ram_valid          <= 1'b0;
      frac               <= '0;
      playback_active    <= 1'b0;
      custom_wave_active <= 1'b0;
      ram_rd_addr        <= '0;
      dds_wave_type      <= '0;
      dds_freq_word      <= '0;
      dds_phase_word     <= '0;
      dds_update         <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      dds_update  <= 1'b0;
      frame_error <= 1'b0;

      // Playback first so parser actions below take priority in the same cycle.
      if (playback_active && ram_valid) begin
        frac <= acc_sum[19:0];
        if (acc_sum[20]) ram_rd_addr <= addr_last ? '0 : ram_rd_addr + 1'b1;
      end

      if (din_vld) begin
        unique case (state)
          IDLE: if (din == 8'hAA) state <= SYNC;
          SYNC: begin
            if (din == 8'h55)      state <= CMD;
            else if (din != 8'hAA) state <= IDLE;
          end
          CMD: begin
            cmd   <= din;
            sum   <= din;
            state <= LEN_H;
          end
          LEN_H: begin
            len[15:8] <= din;
            sum       <= sum + din;
            state     <= LEN_L;
          end
          LEN_L: begin
            len[7:0] <= din;
            sum      <= sum + din;
            idx      <= '0;
            wr_cnt   <= '0;
            // A new upload takes the bus away from the old waveform immediately.
            if (cmd == CMD_CUSTOM) begin
              playback_active    <= 1'b0;
              custom_wave_active <= 1'b0;
            end
            state <= ({len[15:8], din} == 16'd0) ? CHK : PAYLOAD;
          end
          PAYLOAD: begin
            sum <= sum + din;
            idx <= idx + 1'b1;
            if (idx == len - 1'b1) state <= CHK;
            if (cmd == CMD_CUSTOM) begin
              if (idx == 16'd0)      play_req <= din[2];
              else if (idx < 16'd3)  cnt_new  <= {cnt_new[7:0], din};
              else if (idx < 16'd7)  rate_new <= {rate_new[23:0], din};
              else if (idx[0])       lo_byte  <= din;
              else if (wr_ok)        wr_cnt   <= wr_cnt + 1'b1;
            end else if (cmd == CMD_DAC) begin
              if (idx == 16'd0)      dds_new.wave  <= din[1:0];
              else if (idx < 16'd5)  dds_new.freq  <= {dds_new.freq[23:0], din};
              else if (idx < 16'd9)  dds_new.phase <= {dds_new.phase[23:0], din};
            end
          end
          CHK: begin
            state <= IDLE;
            if (cmd == CMD_CUSTOM) begin
              if (up_ok) begin
                cnt_r     <= cnt_new[AW:0];
                rate_r    <= rate_new;
                ram_valid <= 1'b1;
                if (play_req) begin
                  playback_active    <= 1'b1;
                  custom_wave_active <= 1'b1;
                  frac               <= '0;
                  ram_rd_addr        <= '0;
                end
              end else begin
                frame_error <= 1'b1;
                ram_valid   <= 1'b0;
              end
            end else if (cmd == CMD_DAC) begin
              if ((din == sum) && (len == 16'd9)) begin
                dds_wave_type      <= dds_new.wave;
                dds_freq_word      <= dds_new.freq;
                dds_phase_word     <= dds_new.phase;
                dds_update         <= 1'b1;
                playback_active    <= 1'b0;
                custom_wave_active <= 1'b0;
              end else begin
                frame_error <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdc_top.sv
// Directed self-checking bench for cdc_top: builds frames from byte tables,
// checks outputs on the falling edge against hand-derived values.
module tb_cdc_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cdc_top_if bus();

  logic signed [13:0] dac_data;
  logic        custom_wave_active, playback_active;
  logic [11:0] ram_rd_addr;
  logic [1:0]  dds_wave_type;
  logic [31:0] dds_freq_word, dds_phase_word;
  logic        dds_update, frame_error;

  cdc_top dut (
    .clk(clk), .rst_n(rst_n), .usb(bus),
    .dac_data(dac_data), .custom_wave_active(custom_wave_active),
    .playback_active(playback_active), .ram_rd_addr(ram_rd_addr),
    .dds_wave_type(dds_wave_type), .dds_freq_word(dds_freq_word),
    .dds_phase_word(dds_phase_word), .dds_update(dds_update),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  pl[$];
  logic [13:0] smp[4] = '{14'h0000, 14'h2000, 14'h3FFF, 14'h1000};
  logic signed [13:0] expd[4] = '{-14'sd8192, 14'sd0, 14'sd8191, -14'sd4096};
  localparam logic [31:0] FAST = 32'h0010_0000;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.usb_data_in = b;
    bus.usb_data_valid_in = 1'b1;
    @(posedge clk);
    #1 bus.usb_data_valid_in = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd);
    logic [15:0] l;
    l = 16'(pl.size());
    send_byte(8'hAA); send_byte(8'h55); send_byte(cmd);
    send_byte(l[15:8]); send_byte(l[7:0]);
  endtask

  task automatic send_body(input logic [7:0] cmd, input logic [7:0] chk_x);
    logic [15:0] l;
    logic [7:0]  s;
    l = 16'(pl.size());
    s = cmd + l[15:8] + l[7:0];
    foreach (pl[i]) begin s += pl[i]; send_byte(pl[i]); end
    send_byte(s ^ chk_x);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] chk_x);
    send_hdr(cmd);
    send_body(cmd, chk_x);
  endtask

  // Sample 2 carries junk in high-byte bits [7:6] that must be dropped.
  task automatic build_upload(input logic [7:0] ctrl, input logic [15:0] cnt,
                              input logic [31:0] rate, input int nsamp);
    logic [13:0] v;
    pl.delete();
    pl.push_back(ctrl); pl.push_back(cnt[15:8]); pl.push_back(cnt[7:0]);
    pl.push_back(rate[31:24]); pl.push_back(rate[23:16]);
    pl.push_back(rate[15:8]);  pl.push_back(rate[7:0]);
    for (int i = 0; i < nsamp; i++) begin
      v = smp[i % 4];
      pl.push_back(v[7:0]);
      pl.push_back({((i % 4) == 2) ? 2'b11 : 2'b00, v[13:8]});
    end
  endtask

  task automatic build_dds(input logic [1:0] w, input logic [31:0] f, input logic [31:0] p);
    pl.delete();
    pl.push_back({6'd0, w});
    pl.push_back(f[31:24]); pl.push_back(f[23:16]); pl.push_back(f[15:8]); pl.push_back(f[7:0]);
    pl.push_back(p[31:24]); pl.push_back(p[23:16]); pl.push_back(p[15:8]); pl.push_back(p[7:0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dac_data !== 14'sd0) begin errors++; $display("FAIL rst_dac got %0d want 0", dac_data); end
    checks++; if (playback_active !== 1'b0 || custom_wave_active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b%0b want 00", playback_active, custom_wave_active); end
    checks++; if (ram_rd_addr !== 12'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", ram_rd_addr); end
    checks++; if ({dds_wave_type, dds_freq_word, dds_phase_word} !== 66'd0) begin errors++; $display("FAIL rst_dds got %0h %0h %0h want 0", dds_wave_type, dds_freq_word, dds_phase_word); end
    checks++; if (dds_update !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL rst_pulses got %0b%0b want 00", dds_update, frame_error); end
    rst_n = 1'b1;
  endtask

  // rate 0x68: first carry after ceil(2^20/104) = 10083 accumulating clocks.
  task automatic test_upload_slow;
    int n;
    build_upload(8'h04, 16'd4, 32'h68, 4);
    send_frame(8'hFC, 8'h00);
    @(negedge clk);
    checks++; if (playback_active !== 1'b1 || custom_wave_active !== 1'b1) begin errors++; $display("FAIL slow_start got %0b%0b want 11", playback_active, custom_wave_active); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL slow_ferr got %0b want 0", frame_error); end
    n = 0;
    for (int i = 1; i <= 12000; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        checks++; if (dac_data !== -14'sd8192) begin errors++; $display("FAIL slow_dac got %0d want -8192", dac_data); end
      end
      if (ram_rd_addr != 12'd0) begin n = i; break; end
    end
    checks++; if (n != 10083 || ram_rd_addr !== 12'd1) begin errors++; $display("FAIL slow_period got %0d clks addr %0d want 10083 addr 1", n, ram_rd_addr); end
  endtask

  task automatic test_upload_fast;
    build_upload(8'h04, 16'd4, FAST, 4);
    send_frame(8'hFC, 8'h00);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++; if (ram_rd_addr !== 12'(k % 4)) begin errors++; $display("FAIL fast_addr k=%0d got %0d want %0d", k, ram_rd_addr, k % 4); end
      if (k >= 2) begin
        checks++; if (dac_data !== expd[(k - 2) % 4]) begin errors++; $display("FAIL fast_dac k=%0d got %0d want %0d", k, dac_data, expd[(k - 2) % 4]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_play;
    build_upload(8'h00, 16'd4, FAST, 4);
    send_hdr(8'hFC);
    @(negedge clk);
    checks++; if (playback_active !== 1'b0 || custom_wave_active !== 1'b0) begin errors++; $display("FAIL hdr_drop got %0b%0b want 00", playback_active, custom_wave_active); end
    send_body(8'hFC, 8'h00);
    @(negedge clk);
    checks++; if (playback_active !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL noplay_state got pa=%0b fe=%0b want 0 0", playback_active, frame_error); end
    checks++; if (dac_data !== 14'sd0) begin errors++; $display("FAIL noplay_dac got %0d want 0", dac_data); end
  endtask

  task automatic test_reject;
    for (int c = 0; c < 4; c++) begin
      build_upload(8'h04, 16'd4, FAST, 4);   // prime playback so the reject is visible
      send_frame(8'hFC, 8'h00);
      case (c)
        0: build_upload(8'h04, 16'd4,    FAST, 4);
        1: build_upload(8'h04, 16'd0,    FAST, 0);
        2: build_upload(8'h04, 16'd4097, FAST, 4097);
        default: build_upload(8'h04, 16'd4, FAST, 3);
      endcase
      send_frame(8'hFC, (c == 0) ? 8'h01 : 8'h00);
      @(negedge clk);
      checks++; if (frame_error !== 1'b1 || playback_active !== 1'b0) begin errors++; $display("FAIL reject%0d got fe=%0b pa=%0b want 1 0", c, frame_error, playback_active); end
      @(negedge clk);
      checks++; if (frame_error !== 1'b0 || custom_wave_active !== 1'b0) begin errors++; $display("FAIL reject%0d_after got fe=%0b cw=%0b want 0 0", c, frame_error, custom_wave_active); end
    end
  endtask

  task automatic test_dds;
    build_upload(8'h04, 16'd4, FAST, 4);
    send_frame(8'hFC, 8'h00);
    @(negedge clk);
    checks++; if (custom_wave_active !== 1'b1) begin errors++; $display("FAIL dds_pre got %0b want 1", custom_wave_active); end
    build_dds(2'd0, 32'h0100_0000, 32'h0);
    send_frame(8'hFD, 8'h00);
    @(negedge clk);
    checks++; if (dds_update !== 1'b1) begin errors++; $display("FAIL dds_pulse got %0b want 1", dds_update); end
    checks++; if (dds_freq_word !== 32'h0100_0000 || dds_phase_word !== 32'h0 || dds_wave_type !== 2'd0) begin errors++; $display("FAIL dds_fields got %0h %0h %0h want 0 1000000 0", dds_wave_type, dds_freq_word, dds_phase_word); end
    checks++; if (custom_wave_active !== 1'b0 || playback_active !== 1'b0 || dac_data !== 14'sd0) begin errors++; $display("FAIL dds_release got cw=%0b pa=%0b dac=%0d want 0 0 0", custom_wave_active, playback_active, dac_data); end
    @(negedge clk);
    checks++; if (dds_update !== 1'b0) begin errors++; $display("FAIL dds_pulse_end got %0b want 0", dds_update); end
    build_dds(2'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    void'(pl.pop_back());
    send_frame(8'hFD, 8'h00);
    @(negedge clk);
    checks++; if (frame_error !== 1'b1 || dds_update !== 1'b0 || dds_freq_word !== 32'h0100_0000) begin errors++; $display("FAIL dds_badlen got fe=%0b du=%0b f=%0h want 1 0 1000000", frame_error, dds_update, dds_freq_word); end
  endtask

  task automatic test_framing;
    send_byte(8'h00); send_byte(8'hAA);
    build_dds(2'd3, 32'hAA55_AA55, 32'h55AA_AA55);
    send_frame(8'hFD, 8'h00);
    @(negedge clk);
    checks++; if (dds_update !== 1'b1 || dds_wave_type !== 2'd3 || dds_freq_word !== 32'hAA55_AA55 || dds_phase_word !== 32'h55AA_AA55) begin errors++; $display("FAIL stray_sync got du=%0b %0h %0h %0h want 1 3 aa55aa55 55aaaa55", dds_update, dds_wave_type, dds_freq_word, dds_phase_word); end
    pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
    send_frame(8'h10, 8'h00);
    @(negedge clk);
    checks++; if (dds_update !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL unknown_cmd got du=%0b fe=%0b want 0 0", dds_update, frame_error); end
    build_dds(2'd1, 32'h0000_0100, 32'h0000_0200);
    send_frame(8'hFD, 8'h00);
    @(negedge clk);
    checks++; if (dds_update !== 1'b1 || dds_freq_word !== 32'h100 || dds_phase_word !== 32'h200) begin errors++; $display("FAIL after_unknown got du=%0b f=%0h p=%0h want 1 100 200", dds_update, dds_freq_word, dds_phase_word); end
  endtask

  task automatic test_reset_mid;
    build_upload(8'h04, 16'd4, FAST, 4);
    send_frame(8'hFC, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (playback_active !== 1'b0 || custom_wave_active !== 1'b0 || ram_rd_addr !== 12'd0 || dac_data !== 14'sd0) begin errors++; $display("FAIL rst_play got pa=%0b cw=%0b a=%0d d=%0d want 0", playback_active, custom_wave_active, ram_rd_addr, dac_data); end
    @(negedge clk) rst_n = 1'b1;
    build_dds(2'd2, 32'h0000_0300, 32'h0);
    send_frame(8'hFD, 8'h00);
    build_upload(8'h04, 16'd4, FAST, 4);
    send_hdr(8'hFC);
    send_byte(pl[0]); send_byte(pl[1]); send_byte(pl[2]);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dds_freq_word !== 32'h0 || dds_wave_type !== 2'd0) begin errors++; $display("FAIL rst_upload got w=%0h f=%0h want 0 0", dds_wave_type, dds_freq_word); end
    @(negedge clk) rst_n = 1'b1;
    build_dds(2'd1, 32'h0000_0400, 32'h0000_0500);
    send_frame(8'hFD, 8'h00);
    @(negedge clk);
    checks++; if (dds_update !== 1'b1 || dds_freq_word !== 32'h400) begin errors++; $display("FAIL rst_idle got du=%0b f=%0h want 1 400", dds_update, dds_freq_word); end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.usb_data_in = 8'h00;
    bus.usb_data_valid_in = 1'b0;
    test_reset();
    test_upload_slow();
    test_upload_fast();
    test_no_play();
    test_reject();
    test_dds();
    test_framing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
